// File: rtl/pc_hazard_ctrl_pkg.sv
// Shared CPU package: hazard-controller state encoding, register widths and control bundle.
package pc_hazard_ctrl_pkg;

    localparam int unsigned MEM_TIMEOUT_DEF = 64;
    localparam int unsigned REG_W           = 5;
    localparam int unsigned ST_W            = 2;

    localparam logic [ST_W-1:0] ST_RUN       = 2'd0;
    localparam logic [ST_W-1:0] ST_MISS_REQ  = 2'd1;
    localparam logic [ST_W-1:0] ST_MISS_WAIT = 2'd2;
    localparam logic [ST_W-1:0] ST_MISS_DONE = 2'd3;

    // Pipeline-register control bundle driven by the hazard controller.
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
        logic hold;
    } pipe_ctrl_t;

    // Free-running pipeline: PC and IF/ID advance, nothing flushed or held.
    function automatic pipe_ctrl_t ctrl_run();
        pipe_ctrl_t c;
        c.pc_write    = 1'b1;
        c.ifid_write  = 1'b1;
        c.ifid_flush  = 1'b0;
        c.idex_bubble = 1'b0;
        c.hold        = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/pc_hazard_ctrl_hazard_detect.sv
// Load-use hazard detector: load in ID/EX writes a register read by the instruction in IF/ID.
module hazard_detect
    import pc_hazard_ctrl_pkg::*;
(
    input  logic             idex_memread_i,
    input  logic [REG_W-1:0] idex_rt_i,
    input  logic [REG_W-1:0] ifid_rs_i,
    input  logic [REG_W-1:0] ifid_rt_i,
    output logic             load_use_c
);

    // r0 is hard-wired zero, so a load targeting it never creates a dependency.
    always_comb begin
        load_use_c = idex_memread_i && (idex_rt_i != '0) &&
                     ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));
    end

endmodule

// File: rtl/pc_hazard_ctrl.sv
// PC / pipeline hazard controller: cache-miss stall FSM, load-use bubble, branch flush, perf counters.
module pc_hazard_ctrl
    import pc_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             idex_memread_i,
    input  logic [REG_W-1:0] idex_rt_i,
    input  logic [REG_W-1:0] ifid_rs_i,
    input  logic [REG_W-1:0] ifid_rt_i,
    input  logic             branch_taken_i,
    input  logic             dcache_miss_i,
    input  logic             mem_ack_i,
    output logic             mem_req_o,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             hold_o,
    output logic             err_o,
    output logic [CNT_W-1:0] miss_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int unsigned     TMO_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [ST_W-1:0]  state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             err_q, err_d;
    logic             lu_q, lu_d;

    logic             active_c;
    logic             load_use_c;
    logic             lu_stall_c;
    pipe_ctrl_t       ctrl_c;

    hazard_detect u_hazard_detect (
        .idex_memread_i (idex_memread_i),
        .idex_rt_i      (idex_rt_i),
        .ifid_rs_i      (ifid_rs_i),
        .ifid_rt_i      (ifid_rt_i),
        .load_use_c     (load_use_c)
    );

    // Prioritised pipeline control (hold > load-use > branch flush); forced idle in reset or when disabled.
    always_comb begin
        ctrl_c     = ctrl_run();
        active_c   = start_i & rst_i;
        lu_stall_c = 1'b0;
        if (active_c) begin
            if ((state_q != ST_RUN) || dcache_miss_i) begin
                ctrl_c.hold       = 1'b1;
                ctrl_c.pc_write   = 1'b0;
                ctrl_c.ifid_write = 1'b0;
            end else if (load_use_c && !lu_q) begin
                lu_stall_c         = 1'b1;
                ctrl_c.pc_write    = 1'b0;
                ctrl_c.ifid_write  = 1'b0;
                ctrl_c.idex_bubble = 1'b1;
            end else if (branch_taken_i) begin
                ctrl_c.ifid_flush = 1'b1;
            end
        end
    end

    assign pc_write_o    = ctrl_c.pc_write;
    assign ifid_write_o  = ctrl_c.ifid_write;
    assign ifid_flush_o  = ctrl_c.ifid_flush;
    assign idex_bubble_o = ctrl_c.idex_bubble;
    assign hold_o        = ctrl_c.hold;
    assign mem_req_o     = active_c & (state_q == ST_MISS_REQ);
    assign err_o         = err_q;
    assign miss_cnt_o    = miss_cnt_q;
    assign stall_cnt_o   = stall_cnt_q;

    // Miss FSM, refill timeout, sticky error, saturating counters and one-bubble-per-hazard tracking.
    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        miss_cnt_d  = miss_cnt_q;
        stall_cnt_d = stall_cnt_q;
        err_d       = err_q;
        // A bubble already issued stays remembered across a cache hold, since the pipeline is frozen.
        lu_d        = ctrl_c.hold ? lu_q : lu_stall_c;

        if (start_i && !ctrl_c.pc_write && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        if (!start_i) begin
            state_d = ST_RUN;
            tmo_d   = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    tmo_d = '0;
                    if (dcache_miss_i) begin
                        state_d = ST_MISS_REQ;
                        if (miss_cnt_q != CNT_MAX) begin
                            miss_cnt_d = miss_cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_MISS_REQ: begin
                    state_d = ST_MISS_WAIT;
                    tmo_d   = '0;
                end
                ST_MISS_WAIT: begin
                    if (mem_ack_i) begin
                        state_d = ST_MISS_DONE;
                        tmo_d   = '0;
                    end else if (tmo_q == TMO_LAST) begin
                        state_d = ST_RUN;
                        tmo_d   = '0;
                        err_d   = 1'b1;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
                ST_MISS_DONE: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_RUN;
                    tmo_d   = '0;
                end
            endcase
        end
    end

    // State and counter registers, cleared asynchronously by reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_RUN;
            tmo_q       <= '0;
            miss_cnt_q  <= '0;
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
            lu_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            miss_cnt_q  <= miss_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            err_q       <= err_d;
            lu_q        <= lu_d;
        end
    end

endmodule

// File: tb/tb_pc_hazard_ctrl.sv
// Directed bench for pc_hazard_ctrl: vector table for single-cycle control, hand sequences for miss/timeout/reset.
module tb_pc_hazard_ctrl;

    localparam int unsigned CW = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic          idex_memread_i;
    logic [4:0]    idex_rt_i;
    logic [4:0]    ifid_rs_i;
    logic [4:0]    ifid_rt_i;
    logic          branch_taken_i;
    logic          dcache_miss_i;
    logic          mem_ack_i;
    logic          mem_req_o;
    logic          pc_write_o;
    logic          ifid_write_o;
    logic          ifid_flush_o;
    logic          idex_bubble_o;
    logic          hold_o;
    logic          err_o;
    logic [CW-1:0] miss_cnt_o;
    logic [CW-1:0] stall_cnt_o;

    int n_vec = 0;
    int n_bad = 0;

    pc_hazard_ctrl #(.MEM_TIMEOUT(8), .CNT_W(CW)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .idex_memread_i (idex_memread_i),
        .idex_rt_i      (idex_rt_i),
        .ifid_rs_i      (ifid_rs_i),
        .ifid_rt_i      (ifid_rt_i),
        .branch_taken_i (branch_taken_i),
        .dcache_miss_i  (dcache_miss_i),
        .mem_ack_i      (mem_ack_i),
        .mem_req_o      (mem_req_o),
        .pc_write_o     (pc_write_o),
        .ifid_write_o   (ifid_write_o),
        .ifid_flush_o   (ifid_flush_o),
        .idex_bubble_o  (idex_bubble_o),
        .hold_o         (hold_o),
        .err_o          (err_o),
        .miss_cnt_o     (miss_cnt_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic          st;
        logic          mr;
        logic [4:0]    irt;
        logic [4:0]    rs;
        logic [4:0]    rt;
        logic          br;
        logic          ms;
        logic          ak;
        logic          pw;
        logic          iw;
        logic          fl;
        logic          bu;
        logic          ho;
        logic [CW-1:0] scnt;
    } vec_t;

    vec_t tbl [12];

    function automatic vec_t mk(input logic st, input logic mr, input logic [4:0] irt,
                                input logic [4:0] rs, input logic [4:0] rt, input logic br,
                                input logic ms, input logic ak, input logic pw, input logic iw,
                                input logic fl, input logic bu, input logic ho,
                                input logic [CW-1:0] scnt);
        vec_t v;
        v.st = st; v.mr = mr; v.irt = irt; v.rs = rs; v.rt = rt; v.br = br; v.ms = ms; v.ak = ak;
        v.pw = pw; v.iw = iw; v.fl = fl; v.bu = bu; v.ho = ho; v.scnt = scnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic mr, input logic [4:0] irt, input logic [4:0] rs,
                         input logic [4:0] rt, input logic br, input logic ms, input logic ak);
        start_i = st; idex_memread_i = mr; idex_rt_i = irt; ifid_rs_i = rs; ifid_rt_i = rt;
        branch_taken_i = br; dcache_miss_i = ms; mem_ack_i = ak;
    endtask

    task automatic chk_ctrl(input string tag, input logic pw, input logic iw, input logic fl,
                            input logic bu, input logic ho);
        check({tag, ".pc_write"},    32'(pc_write_o),    32'(pw));
        check({tag, ".ifid_write"},  32'(ifid_write_o),  32'(iw));
        check({tag, ".ifid_flush"},  32'(ifid_flush_o),  32'(fl));
        check({tag, ".idex_bubble"}, 32'(idex_bubble_o), 32'(bu));
        check({tag, ".hold"},        32'(hold_o),        32'(ho));
    endtask

    int hold_cnt;
    int req_cnt;

    initial begin
        // start, memread, idex_rt, rs, rt, branch, miss, ack | pc_w, ifid_w, flush, bubble, hold | stall_cnt
        tbl[0]  = mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        tbl[1]  = mk(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        tbl[2]  = mk(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
        tbl[3]  = mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
        tbl[4]  = mk(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
        tbl[5]  = mk(1'b1, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1);
        tbl[6]  = mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2);
        tbl[7]  = mk(1'b1, 1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2);
        tbl[8]  = mk(1'b1, 1'b0, 5'd9, 5'd9, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3);
        tbl[9]  = mk(1'b1, 1'b1, 5'd4, 5'd5, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3);
        tbl[10] = mk(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3);
        tbl[11] = mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3);

        // Reset with an active miss on the inputs: outputs must still show the reset values.
        rst_i = 1'b0;
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        repeat (2) @(negedge clk_i);
        chk_ctrl("rst", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("rst.mem_req",   32'(mem_req_o),   0);
        check("rst.err",       32'(err_o),       0);
        check("rst.miss_cnt",  32'(miss_cnt_o),  0);
        check("rst.stall_cnt", 32'(stall_cnt_o), 0);
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        rst_i = 1'b1;

        // Single-cycle control vectors.
        for (int i = 0; i < 12; i++) begin
            @(posedge clk_i); #1;
            drive(tbl[i].st, tbl[i].mr, tbl[i].irt, tbl[i].rs, tbl[i].rt, tbl[i].br, tbl[i].ms, tbl[i].ak);
            @(negedge clk_i);
            chk_ctrl($sformatf("vec%0d", i), tbl[i].pw, tbl[i].iw, tbl[i].fl, tbl[i].bu, tbl[i].ho);
            check($sformatf("vec%0d.mem_req", i),   32'(mem_req_o),   0);
            check($sformatf("vec%0d.stall_cnt", i), 32'(stall_cnt_o), 32'(tbl[i].scnt));
        end
        @(posedge clk_i); #1;
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk_i);
        check("tbl.stall_cnt", 32'(stall_cnt_o), 3);
        check("tbl.miss_cnt",  32'(miss_cnt_o),  0);
        check("tbl.err",       32'(err_o),       0);

        // Miss serviced: ack three cycles after the request pulse; miss drops once serviced.
        hold_cnt = 0; req_cnt = 0;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk_i); #1;
            drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, (k < 5), (k == 4));
            @(negedge clk_i);
            hold_cnt += int'(hold_o);
            req_cnt  += int'(mem_req_o);
            if (k == 1) check("miss.req_cycle", 32'(mem_req_o), 1);
        end
        check("miss.hold_cycles", 32'(hold_cnt),    6);
        check("miss.req_pulses",  32'(req_cnt),     1);
        check("miss.miss_cnt",    32'(miss_cnt_o),  1);
        check("miss.stall_cnt",   32'(stall_cnt_o), 9);

        // Refill never acknowledged: abort after 8 wait cycles, sticky error, stall counter saturates.
        req_cnt = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk_i); #1;
            drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, (k < 10), 1'b0);
            @(negedge clk_i);
            req_cnt += int'(mem_req_o);
            if (k == 9) check("tmo.err_before", 32'(err_o), 0);
            if (k == 10) begin
                check("tmo.err_set",   32'(err_o),       1);
                check("tmo.hold_off",  32'(hold_o),      0);
                check("tmo.pc_write",  32'(pc_write_o),  1);
                check("tmo.stall_sat", 32'(stall_cnt_o), 15);
            end
        end
        check("tmo.err_sticky", 32'(err_o),      1);
        check("tmo.req_pulses", 32'(req_cnt),    1);
        check("tmo.miss_cnt",   32'(miss_cnt_o), 2);

        // start_i dropped mid-miss: back to RUN, no request, counters kept; repeated to saturate miss_cnt.
        for (int i = 0; i < 16; i++) begin
            @(posedge clk_i); #1;
            drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
            @(negedge clk_i);
            if (i == 0) check("abort.hold_run", 32'(hold_o), 1);
            @(posedge clk_i); #1;
            drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
            @(negedge clk_i);
            if (i == 0) begin
                check("abort.req_off",  32'(mem_req_o), 0);
                check("abort.hold_off", 32'(hold_o),    0);
            end
            @(posedge clk_i); #1;
            drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
            @(negedge clk_i);
            if (i == 0) begin
                check("abort.run_hold", 32'(hold_o),     0);
                check("abort.miss_cnt", 32'(miss_cnt_o), 3);
            end
        end
        check("abort.miss_sat",  32'(miss_cnt_o),  15);
        check("abort.stall_sat", 32'(stall_cnt_o), 15);

        // Miss, load-use and taken branch together: only the hold is visible.
        @(posedge clk_i); #1;
        drive(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0);
        @(negedge clk_i);
        chk_ctrl("prio", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk_i);
        @(negedge clk_i);
        check("prio.req", 32'(mem_req_o), 1);
        @(posedge clk_i);
        @(negedge clk_i);
        check("wait.req",  32'(mem_req_o), 0);
        check("wait.hold", 32'(hold_o),    1);

        // Asynchronous reset in MISS_WAIT, between clock edges.
        #2;
        rst_i = 1'b0;
        #1;
        chk_ctrl("arst", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("arst.mem_req",   32'(mem_req_o),   0);
        check("arst.err",       32'(err_o),       0);
        check("arst.miss_cnt",  32'(miss_cnt_o),  0);
        check("arst.stall_cnt", 32'(stall_cnt_o), 0);
        req_cnt = 0;
        repeat (2) begin
            @(negedge clk_i);
            req_cnt += int'(mem_req_o);
        end
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        rst_i = 1'b1;
        repeat (4) begin
            @(negedge clk_i);
            req_cnt += int'(mem_req_o) + int'(hold_o);
        end
        check("arst.no_refill", 32'(req_cnt),    0);
        check("arst.miss_kept", 32'(miss_cnt_o), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
